// File: rtl/hpu_pkg.sv
// Shared types and core-pipeline timing constants for the core-array control stage.
package hpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } seq_state_t;

  // Cycles from exec to the sum landing in acc_left, and from init to the clear.
  localparam int CORE_EXEC_LAT = 3;
  localparam int CORE_INIT_LAT = 2;

endpackage

// File: rtl/core_sequencer.sv
// Control stage for one core chain: feeds item indices into every core, waits out the
// core pipeline, then shifts all NCORE accumulators out through core 0.
module core_sequencer
  import hpu_pkg::*;
#(
  parameter int NCORE = 8,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [NCORE*DW-1:0] s_data,
  input  logic                s_last,
  output logic                init,
  output logic                exec,
  output logic [NCORE*DW-1:0] exec_src_data,
  output logic                update,
  output logic                out_period,
  input  logic [DW-1:0]       acc_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DW-1:0]       m_data,
  output logic                m_last,
  output logic                busy
);

  localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NCORE - 1);
  localparam logic [1:0]    CNT_LAST = 2'(CORE_EXEC_LAT - 1);

  seq_state_t          state_q;
  logic [IW-1:0]       idx_q;
  logic [1:0]          cnt_q;
  logic [NCORE*DW-1:0] src_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      src_q   <= '0;
    end else begin
      case (state_q)
        // The beat that woke us is left on the bus and taken in RUN.
        IDLE: if (s_valid) state_q <= INIT;
        INIT: state_q <= RUN;
        RUN: begin
          if (s_valid) begin
            src_q <= s_data;
            if (s_last) begin
              state_q <= DRAIN;
              cnt_q   <= '0;
            end
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= OUT;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        OUT: begin
          if (m_ready) begin
            if (idx_q == IDX_LAST) begin
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Every output is decoded from registered state; only the two handshakes are combinational.
  assign s_ready       = (state_q == RUN);
  assign exec          = s_valid && s_ready;
  assign init          = (state_q == INIT);
  assign exec_src_data = src_q;
  assign m_valid       = (state_q == OUT);
  assign m_data        = acc_in;
  assign m_last        = m_valid && (idx_q == IDX_LAST);
  // Word 0 reads acc_left directly and the same cycle's shift loads acc_left of the neighbour.
  assign update        = m_valid && (idx_q == '0);
  assign out_period    = m_valid && m_ready;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer with a behavioural core chain and a sum-per-lane reference.
module tb_core_sequencer;

  localparam int NCORE = 8;
  localparam int DW    = 32;
  localparam int MAXB  = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [NCORE*DW-1:0] s_data = '0;
  logic                s_last = 1'b0;
  logic                init, exec, update, out_period;
  logic [NCORE*DW-1:0] exec_src_data;
  logic [DW-1:0]       acc_in;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic [DW-1:0]       m_data;
  logic                m_last;
  logic                busy;

  core_sequencer #(.NCORE(NCORE), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .init(init), .exec(exec), .exec_src_data(exec_src_data),
    .update(update), .out_period(out_period), .acc_in(acc_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural core chain: item_memory[i] = i, clear lands 2 edges after init,
  // index sampled the cycle after exec, sum lands 3 edges after exec.
  logic [DW-1:0] acc_left  [NCORE];
  logic [DW-1:0] acc_right [NCORE];
  logic [DW-1:0] item      [NCORE];
  logic          init_d1, exec_d1, item_v;

  always @(posedge clk) begin
    if (rst) begin
      init_d1 <= 1'b0;
      exec_d1 <= 1'b0;
      item_v  <= 1'b0;
      for (int i = 0; i < NCORE; i++) begin
        acc_left[i]  <= '0;
        acc_right[i] <= '0;
        item[i]      <= '0;
      end
    end else begin
      init_d1 <= init;
      exec_d1 <= exec;
      item_v  <= exec_d1;
      for (int i = 0; i < NCORE; i++) begin
        if (exec_d1) item[i] <= exec_src_data[i*DW +: DW];
        if (init_d1) acc_left[i] <= '0;
        else if (item_v) acc_left[i] <= acc_left[i] + item[i];
        if (out_period) begin
          if (i < NCORE - 1) acc_right[i] <= update ? acc_left[i+1] : acc_right[i+1];
          else acc_right[i] <= '0;
        end
      end
    end
  end

  assign acc_in = update ? acc_left[0] : acc_right[0];

  int n_cmp = 0;
  int n_err = 0;
  int exec_cnt = 0, op_cnt = 0, bad_op = 0;
  int unsigned fb [MAXB][NCORE];
  int cur_nb = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (exec) exec_cnt++;
      if (out_period) op_cnt++;
      if (out_period && !(m_valid && m_ready)) bad_op++;
    end
  end

  function automatic logic [DW-1:0] exp_word(input int k);
    logic [DW-1:0] s = '0;
    for (int b = 0; b < cur_nb; b++) s += DW'(fb[b][k]);
    return s;
  endfunction

  task automatic present(input int beat);
    s_valid = 1'b1;
    s_last  = (beat == cur_nb - 1);
    for (int k = 0; k < NCORE; k++) s_data[k*DW +: DW] = DW'(fb[beat][k]);
  endtask

  task automatic fill_random(input int nb);
    cur_nb = nb;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < NCORE; k++) fb[b][k] = $urandom_range(0, 1000);
  endtask

  // Drives cur_nb beats; gap idle cycles after each beat (random 0..3 if rnd_gap);
  // returns early with s_valid low once abort_at beats have been accepted.
  task automatic send_frame(input int gap, input bit rnd_gap, input int abort_at);
    int beat = 0;
    int idle = 0;
    int cyc = 0;
    bit hs;
    exec_cnt = 0; op_cnt = 0; bad_op = 0;
    present(0);
    while (beat < cur_nb) begin
      if (abort_at >= 0 && beat == abort_at) begin
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      if (cyc > 300) begin
        chk("s_handshake_timeout", 64'(beat), 64'(cur_nb));
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        beat++;
        if (beat < cur_nb) begin
          idle = rnd_gap ? int'($urandom_range(0, 3)) : gap;
          if (idle == 0) present(beat);
          else s_valid = 1'b0;
        end else begin
          s_valid = 1'b0; s_last = 1'b0;
        end
      end else if (idle > 0) begin
        idle--;
        if (idle == 0) present(beat);
      end
    end
  endtask

  task automatic collect(input bit stall);
    int words = 0;
    int cyc = 0;
    bit seen = 0;
    while (words < NCORE) begin
      if (cyc > 400) begin
        chk("m_word_timeout", 64'(words), 64'(NCORE));
        break;
      end
      @(posedge clk); #1;
      cyc++;
      m_ready = stall ? (seen ? 1'($urandom_range(0, 1)) : 1'b0) : 1'b1;
      @(negedge clk);
      if (m_valid) begin
        seen = 1;
        if (m_ready) begin
          chk($sformatf("m_data[%0d]", words), 64'(m_data), 64'(exp_word(words)));
          chk($sformatf("m_last[%0d]", words), 64'(m_last), 64'(words == NCORE - 1));
          chk($sformatf("update[%0d]", words), 64'(update), 64'(words == 0));
          words++;
        end else if (words == 0) begin
          chk("update_held_w0", 64'(update), 64'd1);
        end
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
    chk("m_valid_after", 64'(m_valid), 64'd0);
    chk("exec_pulses", 64'(exec_cnt), 64'(cur_nb));
    chk("out_period_pulses", 64'(op_cnt), 64'(NCORE));
    chk("out_period_off_hs", 64'(bad_op), 64'd0);
    $display("frame beats=%0d stall=%0d words=%0d", cur_nb, stall, words);
  endtask

  task automatic reset_check(input string tag);
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ctrl"}, 64'({s_ready, init, exec, update, out_period, m_valid, m_last, busy}), 64'd0);
    chk({tag, "_src"}, 64'(|exec_src_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset %s checked", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'({s_ready, init, exec, update, out_period, m_valid, m_last, busy}), 64'd0);
    chk("reset_src", 64'(|exec_src_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single beat, all lanes 5
    cur_nb = 1;
    for (int k = 0; k < NCORE; k++) fb[0][k] = 5;
    send_frame(0, 0, -1);
    collect(0);

    // Three beats, lane i = {i, 2i, 10}
    cur_nb = 3;
    for (int k = 0; k < NCORE; k++) begin
      fb[0][k] = k; fb[1][k] = 2 * k; fb[2][k] = 10;
    end
    send_frame(0, 0, -1);
    collect(0);

    // Back-to-back random frames
    for (int f = 0; f < 2; f++) begin
      fill_random(int'($urandom_range(1, 4)));
      send_frame(0, 0, -1);
      collect(0);
    end

    // Random output stalls, starting low on word 0
    fill_random(3);
    send_frame(0, 0, -1);
    collect(1);

    // Beat, three idle cycles, beat
    fill_random(2);
    send_frame(3, 0, -1);
    collect(0);

    // Reset in RUN, then a clean frame
    fill_random(3);
    send_frame(0, 0, 2);
    reset_check("rst_in_run");
    fill_random(2);
    send_frame(0, 0, -1);
    collect(0);

    // Reset in OUT, then a clean frame
    fill_random(2);
    send_frame(0, 0, -1);
    begin
      int w = 0;
      while (!m_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
    end
    chk("reached_out", 64'(m_valid), 64'd1);
    reset_check("rst_in_out");
    fill_random(3);
    send_frame(0, 1, -1);
    collect(1);

    // Mixed random frames
    for (int f = 0; f < 6; f++) begin
      fill_random(int'($urandom_range(1, MAXB)));
      send_frame(0, 1, -1);
      collect(f[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
